mips_mdu: RTL

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU serially, one bit per cycle, and exposes busy/done so the controller can stall dependent MFHI/MFLO. It also accepts MTHI/MTLO writes. It sits beside the ALU in the datapath and is driven from the controller's decoded operation.

---
 rtl/mips_mdu.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mips_mdu.sv
// mips_mdu: serial multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU are computed one bit per cycle on operand magnitudes.
// A FIX cycle then applies the result signs and writes HI/LO.
// MTHI/MTLO writes are accepted in any state. A result write on the same
// edge takes precedence over them.
// Ports:
//   clk, rst (async, active high)
//   start, op[1:0], a, b  launch; sampled only in IDLE
//                         op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush                 abandon the operation in flight; no HI/LO write
//   hi_we, lo_we, wdata   MTHI / MTLO
//   busy                  operation in flight
//   done                  one-cycle pulse when HI/LO take a result
//   hi, lo                architectural HI/LO
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  logic [CW-1:0]        cnt;
  logic                 last;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div0;
  logic [WIDTH-1:0]     ma;
  logic [WIDTH-1:0]     mb;
  logic [2*WIDTH-1:0]   acc;

  logic                 signed_op;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   mul_step;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_mag;
  logic [WIDTH-1:0]     r_mag;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;
  logic [WIDTH-1:0]     hi_res;
  logic [WIDTH-1:0]     lo_res;

  // Operand conditioning. op[0] set means an unsigned op.
  assign signed_op = ~op[0];
  assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // The add is one bit wider so that its carry shifts into the top bit.
  assign msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
  assign mul_step = {msum, acc[WIDTH-1:1]};

  // Restoring divide: acc = {remainder, dividend bits / quotient bits}.
  // Bit WIDTH of the trial difference is set when the subtraction would go negative.
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mb};
  assign div_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix. Both neg flags are cleared for unsigned ops.
  // With a zero divisor, the remainder magnitude is |a|. The sign fix then
  // restores the raw dividend.
  assign prod_fix = neg_q ? -acc : acc;
  assign q_mag    = acc[WIDTH-1:0];
  assign r_mag    = acc[2*WIDTH-1:WIDTH];
  assign q_fix    = neg_q ? -q_mag : q_mag;
  assign r_fix    = neg_r ? -r_mag : r_mag;
  assign hi_res   = is_div ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res   = is_div ? (div0 ? '1 : q_fix) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // CALC holds one extra cycle after the final iteration. This keeps the
  // start-to-result latency at WIDTH+2 edges, which the controller's stall
  // timing assumes.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (flush) state_nx = IDLE;
               else if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      last   <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      case (state)
        IDLE: if (start) begin
          ma     <= a_abs;
          mb     <= b_abs;
          acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
          is_div <= op[1];
          neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r  <= signed_op & a[WIDTH-1];
          div0   <= (b == '0);
          cnt    <= CW'(WIDTH - 1);
          last   <= 1'b0;
        end
        CALC: if (!flush && !last) begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) last <= 1'b1;
        end
        FIX: if (!flush) begin
          hi   <= hi_res;
          lo   <= lo_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
